// File: rtl/wb_memwin_pkg.sv
// Shared constants for the Wishbone memory window: legal response latency
// range and the width/ceiling of the saturating error counter.
`timescale 1ns/1ps
package wb_memwin_pkg;

    localparam int LAT_MIN   = 1;
    localparam int LAT_MAX   = 4;
    localparam int ERR_CNT_W = 16;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

    // Out-of-range latencies are pinned to the nearest legal value.
    function automatic int clamp_lat(input int lat);
        if (lat < LAT_MIN) return LAT_MIN;
        if (lat > LAT_MAX) return LAT_MAX;
        return lat;
    endfunction

endpackage

// File: rtl/wb_bytemem.sv
// Byte-lane memory: one independent byte array per lane, registered read,
// lane-enabled write. Each lane maps onto a block RAM with one write enable.
`timescale 1ns/1ps
module wb_bytemem
    import wb_memwin_pkg::*;
#(
    parameter int MAW = 15,
    parameter int DW  = 32
) (
    input  logic              i_clk,
    input  logic              we,
    input  logic              re,
    input  logic [MAW-1:0]    addr,
    input  logic [DW-1:0]     wdata,
    input  logic [DW/8-1:0]   sel,
    output logic [DW-1:0]     rdata
);

    localparam int NB    = DW / 8;
    localparam int DEPTH = 1 << MAW;

    for (genvar b = 0; b < NB; b++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];
        logic [7:0] lane_q;

        // Read-first: a same-edge read sees the old byte; the next cycle sees the new one.
        always_ff @(posedge i_clk) begin
            if (we && sel[b])
                lane_mem[addr] <= wdata[b*8 +: 8];
            if (re)
                lane_q <= lane_mem[addr];
        end

        assign rdata[b*8 +: 8] = lane_q;
    end

endmodule

// File: rtl/wb_memwin.sv
// Wishbone pipelined slave exposing a byte-enabled memory in one address window;
// fixed-latency in-order responses, err for out-of-window, saturating err count.
`timescale 1ns/1ps
module wb_memwin
    import wb_memwin_pkg::*;
#(
    parameter int AW   = 28,
    parameter int MAW  = 15,
    parameter int DW   = 32,
    parameter int BASE = 1,
    parameter int LAT  = 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_wb_cyc,
    input  logic                 i_wb_stb,
    input  logic                 i_wb_we,
    input  logic [AW-1:0]        i_wb_addr,
    input  logic [DW-1:0]        i_wb_data,
    input  logic [DW/8-1:0]      i_wb_sel,
    input  logic                 i_stall_req,
    output logic                 o_wb_stall,
    output logic                 o_wb_ack,
    output logic                 o_wb_err,
    output logic [DW-1:0]        o_wb_data,
    output logic [ERR_CNT_W-1:0] o_err_count
);

    localparam int STAGES = clamp_lat(LAT);
    localparam int NB     = DW / 8;
    localparam logic [AW-MAW-1:0] BASE_TAG = BASE[AW-MAW-1:0];

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [NB-1:0] sel;
    } req_t;

    typedef struct packed {
        logic          vld;
        logic          err;
        logic [DW-1:0] data;
    } rsp_t;

    req_t  req;
    rsp_t  rsp;
    logic  accept;
    logic  in_win;
    logic  [DW-1:0] mem_rdata;
    logic  [DW-1:0] rsp_data;
    logic  [STAGES:1] vld_pipe;
    logic  [STAGES:1] err_pipe;
    logic  [ERR_CNT_W-1:0] err_cnt;

    assign req = '{we: i_wb_we, addr: i_wb_addr, data: i_wb_data, sel: i_wb_sel};

    assign o_wb_stall = i_stall_req;
    assign accept     = i_wb_cyc && i_wb_stb && !o_wb_stall;
    assign in_win     = (req.addr[AW-1:MAW] == BASE_TAG);

    wb_bytemem #(
        .MAW (MAW),
        .DW  (DW)
    ) u_mem (
        .i_clk (i_clk),
        .we    (accept && req.we && in_win),
        .re    (accept),
        .addr  (req.addr[MAW-1:0]),
        .wdata (req.data),
        .sel   (req.sel),
        .rdata (mem_rdata)
    );

    // Stage 1 is the accept edge itself; dropping cyc empties every later stage.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            vld_pipe <= '0;
            err_pipe <= '0;
        end else begin
            vld_pipe[1] <= accept;
            err_pipe[1] <= !in_win;
            for (int s = 2; s <= STAGES; s++) begin
                vld_pipe[s] <= i_wb_cyc && vld_pipe[s-1];
                err_pipe[s] <= err_pipe[s-1];
            end
        end
    end

    // The RAM output register already holds stage-1 data; later stages just delay it.
    if (STAGES == 1) begin : g_dat_lat1
        assign rsp_data = mem_rdata;
    end else begin : g_dat_latn
        logic [STAGES-2:0][DW-1:0] dat_sr;

        always_ff @(posedge i_clk) begin
            dat_sr[0] <= mem_rdata;
            for (int s = 1; s < STAGES - 1; s++)
                dat_sr[s] <= dat_sr[s-1];
        end

        assign rsp_data = dat_sr[STAGES-2];
    end

    assign rsp = '{vld: vld_pipe[STAGES], err: err_pipe[STAGES], data: rsp_data};

    assign o_wb_ack  = rsp.vld && !rsp.err;
    assign o_wb_err  = rsp.vld &&  rsp.err;
    assign o_wb_data = rsp.vld ? rsp.data : '0;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            err_cnt <= '0;
        else if (o_wb_err && err_cnt != ERR_CNT_MAX)
            err_cnt <= err_cnt + 1'b1;
    end

    assign o_err_count = err_cnt;

endmodule

// File: tb/tb_wb_memwin.sv
// Directed bench for wb_memwin: three instances (LAT 1, 3, 4) driven by a
// vector table plus hand-written burst/stall, abort, saturation and reset cases.
`timescale 1ns/1ps
module tb_wb_memwin;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc   [N];
    logic        stb   [N];
    logic        we    [N];
    logic        stall [N];
    logic [27:0] addr  [N];
    logic [31:0] wdat  [N];
    logic [3:0]  sel   [N];
    logic        wstall[N];
    logic        ack   [N];
    logic        err   [N];
    logic [31:0] rdat  [N];
    logic [15:0] ecnt  [N];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        wb_memwin #(
            .AW(28), .MAW(15), .DW(32), .BASE(1),
            .LAT(g == 0 ? 1 : (g == 1 ? 3 : 4))
        ) u_dut (
            .i_clk       (clk),
            .i_reset_n   (rst_n),
            .i_wb_cyc    (cyc[g]),
            .i_wb_stb    (stb[g]),
            .i_wb_we     (we[g]),
            .i_wb_addr   (addr[g]),
            .i_wb_data   (wdat[g]),
            .i_wb_sel    (sel[g]),
            .i_stall_req (stall[g]),
            .o_wb_stall  (wstall[g]),
            .o_wb_ack    (ack[g]),
            .o_wb_err    (err[g]),
            .o_wb_data   (rdat[g]),
            .o_err_count (ecnt[g])
        );
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // ack and err must never coincide on any instance.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int k = 0; k < N; k++) begin
                n_chk++;
                if (ack[k] && err[k]) begin
                    n_fail++;
                    $display("FAIL ack_err_excl[%0d]: got ack=1 err=1, expected not both", k);
                end
            end
        end
    end

    // One request on instance k; response checked exactly lat cycles after accept, then quiet.
    task automatic txn(input int k, input int lat, input logic w, input logic [27:0] a,
                       input logic [31:0] d, input logic [3:0] s, input logic exp_err,
                       input logic chk_d, input logic [31:0] exp_d, input string nm);
        @(negedge clk);
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; addr[k] = a; wdat[k] = d; sel[k] = s;
        @(negedge clk);
        stb[k] = 1'b0;
        repeat (lat - 1) @(negedge clk);
        chk({nm, ".ack"}, {31'd0, ack[k]}, {31'd0, !exp_err});
        chk({nm, ".err"}, {31'd0, err[k]}, {31'd0, exp_err});
        if (chk_d) chk({nm, ".data"}, rdat[k], exp_d);
        @(negedge clk);
        chk({nm, ".quiet"}, {30'd0, ack[k], err[k]}, 32'd0);
        cyc[k] = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [27:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
        logic        exp_err;
        logic        chk_d;
        logic [31:0] exp_d;
    } vec_t;

    vec_t vt [14];

    initial begin
        vt[0]  = '{1'b1, 28'h0008010, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 32'h0};
        vt[1]  = '{1'b0, 28'h0008010, 32'h0,        4'hF, 1'b0, 1'b1, 32'hDEADBEEF};
        vt[2]  = '{1'b1, 28'h0008020, 32'hAABBCCDD, 4'hF, 1'b0, 1'b0, 32'h0};
        vt[3]  = '{1'b1, 28'h0008020, 32'h11223344, 4'h5, 1'b0, 1'b0, 32'h0};
        vt[4]  = '{1'b0, 28'h0008020, 32'h0,        4'hF, 1'b0, 1'b1, 32'hAA22CC44};
        vt[5]  = '{1'b0, 28'h0010000, 32'h0,        4'hF, 1'b1, 1'b0, 32'h0};
        vt[6]  = '{1'b1, 28'h0000010, 32'h12345678, 4'hF, 1'b1, 1'b0, 32'h0};
        vt[7]  = '{1'b0, 28'h0008010, 32'h0,        4'hF, 1'b0, 1'b1, 32'hDEADBEEF};
        vt[8]  = '{1'b1, 28'h000FFFF, 32'hCAFEF00D, 4'hF, 1'b0, 1'b0, 32'h0};
        vt[9]  = '{1'b0, 28'h000FFFF, 32'h0,        4'hF, 1'b0, 1'b1, 32'hCAFEF00D};
        vt[10] = '{1'b0, 28'h0007FFF, 32'h0,        4'hF, 1'b1, 1'b0, 32'h0};
        vt[11] = '{1'b1, 28'h0008010, 32'h00000000, 4'h0, 1'b0, 1'b0, 32'h0};
        vt[12] = '{1'b0, 28'h0008010, 32'h0,        4'hF, 1'b0, 1'b1, 32'hDEADBEEF};
        vt[13] = '{1'b0, 28'h0808010, 32'h0,        4'hF, 1'b1, 1'b0, 32'h0};

        rst_n = 1'b0;
        for (int k = 0; k < N; k++) begin
            cyc[k] = 0; stb[k] = 0; we[k] = 0; stall[k] = 0;
            addr[k] = '0; wdat[k] = '0; sel[k] = '0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("rst.ack%0d", k),  {31'd0, ack[k]}, 32'd0);
            chk($sformatf("rst.err%0d", k),  {31'd0, err[k]}, 32'd0);
            chk($sformatf("rst.data%0d", k), rdat[k], 32'd0);
            chk($sformatf("rst.ecnt%0d", k), {16'd0, ecnt[k]}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Stall mirrors the request input
        stall[0] = 1'b1; #1;
        chk("stall.hi", {31'd0, wstall[0]}, 32'd1);
        stall[0] = 1'b0; #1;
        chk("stall.lo", {31'd0, wstall[0]}, 32'd0);

        // Table of single transactions, LAT = 1
        for (int i = 0; i < 14; i++)
            txn(0, 1, vt[i].we, vt[i].addr, vt[i].data, vt[i].sel,
                vt[i].exp_err, vt[i].chk_d, vt[i].exp_d, $sformatf("vec%0d", i));
        chk("ecnt.after_table", {16'd0, ecnt[0]}, 32'd4);

        // stb without cyc is ignored: no response, no write
        @(negedge clk);
        cyc[0] = 0; stb[0] = 1; we[0] = 1; addr[0] = 28'h0008010; wdat[0] = 32'h0BADF00D; sel[0] = 4'hF;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk($sformatf("nocyc.quiet%0d", n), {30'd0, ack[0], err[0]}, 32'd0);
        end
        stb[0] = 0;
        txn(0, 1, 1'b0, 28'h0008010, 32'h0, 4'hF, 1'b0, 1'b1, 32'hDEADBEEF, "nocyc.read");

        // Back-to-back write then read of the same word
        @(negedge clk);
        cyc[0] = 1; stb[0] = 1; we[0] = 1; addr[0] = 28'h0008030; wdat[0] = 32'h5A5AA5A5; sel[0] = 4'hF;
        @(negedge clk);
        chk("b2b.wr_ack", {31'd0, ack[0]}, 32'd1);
        we[0] = 0;
        @(negedge clk);
        stb[0] = 0;
        chk("b2b.rd_ack", {31'd0, ack[0]}, 32'd1);
        chk("b2b.rd_data", rdat[0], 32'h5A5AA5A5);
        @(negedge clk);
        chk("b2b.quiet", {30'd0, ack[0], err[0]}, 32'd0);
        cyc[0] = 0;

        // LAT = 3: prefill, then 4 reads with a 2-cycle stall mid-burst
        for (int i = 1; i <= 4; i++)
            txn(1, 3, 1'b1, 28'h0008000 + 28'(i), 32'h00001000 + 32'(i), 4'hF,
                1'b0, 1'b0, 32'h0, $sformatf("l3.fill%0d", i));
        cyc[1] = 1; we[1] = 0; sel[1] = 4'hF;
        for (int n = 0; n < 12; n++) begin
            int idx;
            @(negedge clk);
            idx = (n == 3) ? 1 : (n == 4) ? 2 : (n == 7) ? 3 : (n == 8) ? 4 : 0;
            chk($sformatf("l3.ack@%0d", n), {31'd0, ack[1]}, {31'd0, idx != 0});
            if (idx != 0) chk($sformatf("l3.data@%0d", n), rdat[1], 32'h00001000 + 32'(idx));
            case (n)
                0: begin stb[1] = 1; addr[1] = 28'h0008001; end
                1: addr[1] = 28'h0008002;
                2: begin stall[1] = 1; addr[1] = 28'h0008003; end
                4: stall[1] = 0;
                5: addr[1] = 28'h0008004;
                6: stb[1] = 0;
                default: ;
            endcase
        end
        cyc[1] = 0;

        // LAT = 4: cyc dropped 2 cycles after accept aborts the response
        @(negedge clk);
        cyc[2] = 1; stb[2] = 1; we[2] = 0; addr[2] = 28'h0008001; sel[2] = 4'hF;
        for (int n = 1; n < 8; n++) begin
            @(negedge clk);
            chk($sformatf("abort.quiet%0d", n), {30'd0, ack[2], err[2]}, 32'd0);
            if (n == 1) stb[2] = 0;
            if (n == 2) cyc[2] = 0;
            if (n == 4) cyc[2] = 1;
        end
        cyc[2] = 0;
        txn(2, 4, 1'b1, 28'h0008040, 32'h77665544, 4'hF, 1'b0, 1'b0, 32'h0, "abort.wr");
        txn(2, 4, 1'b0, 28'h0008040, 32'h0, 4'hF, 1'b0, 1'b1, 32'h77665544, "abort.rd");

        // Error counter saturation
        @(negedge clk);
        cyc[0] = 1; stb[0] = 1; we[0] = 0; addr[0] = 28'h0010000;
        repeat (65537) @(negedge clk);
        stb[0] = 0;
        repeat (2) @(negedge clk);
        chk("ecnt.sat", {16'd0, ecnt[0]}, 32'h0000FFFF);

        // Reset with a pending LAT=4 response discards it
        cyc[2] = 1; stb[2] = 1; we[2] = 0; addr[2] = 28'h0008040;
        @(negedge clk);
        stb[2] = 0;
        @(negedge clk);
        rst_n = 1'b0; #1;
        chk("rst2.ecnt", {16'd0, ecnt[0]}, 32'd0);
        chk("rst2.resp", {30'd0, ack[2], err[2]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            chk($sformatf("rst2.quiet%0d", n), {30'd0, ack[2], err[2]}, 32'd0);
        end
        chk("rst2.ecnt_hold", {16'd0, ecnt[0]}, 32'd0);
        cyc[0] = 0; cyc[2] = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_memwin.md
WB_MEMWIN -- requirements
Module: wb_memwin

Interface
REQ-001 The module SHALL have parameter AW, default 28: bus word-address width.
REQ-002 The module SHALL have parameter MAW, default 15: memory word-address width, with MAW < AW.
REQ-003 The module SHALL have parameter DW, default 32: data width, a multiple of 8.
REQ-004 The module SHALL have parameter BASE, default 1: required value of address bits [AW-1:MAW].
REQ-005 The module SHALL have parameter LAT, default 1: accept-to-response latency in cycles, legal range 1..4.
REQ-006 The module SHALL have port i_clk, input, 1 bit: the single clock.
REQ-007 The module SHALL have port i_reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 The module SHALL have ports i_wb_cyc, i_wb_stb, i_wb_we, each input, 1 bit: Wishbone pipelined cycle, strobe and write-enable.
REQ-009 The module SHALL have port i_wb_addr, input, AW bits: word address.
REQ-010 The module SHALL have port i_wb_data, input, DW bits: write data.
REQ-011 The module SHALL have port i_wb_sel, input, DW/8 bits: byte enables.
REQ-012 The module SHALL have port i_stall_req, input, 1 bit: external stall injection.
REQ-013 The module SHALL have port o_wb_stall, output, 1 bit: slave stall.
REQ-014 The module SHALL have ports o_wb_ack and o_wb_err, each output, 1 bit: response strobes.
REQ-015 The module SHALL have port o_wb_data, output, DW bits: read data.
REQ-016 The module SHALL have port o_err_count, output, 16 bits: saturating count of issued errors.

Function
REQ-017 o_wb_stall SHALL equal i_stall_req combinationally.
REQ-018 A request SHALL be accepted in a cycle with i_wb_cyc && i_wb_stb && !o_wb_stall; i_wb_stb without i_wb_cyc is ignored.
REQ-019 In-window test: an accepted request is in-window iff i_wb_addr[AW-1:MAW] == BASE.
REQ-020 In-window write: memory word i_wb_addr[MAW-1:0] SHALL be updated on the accept edge, only in bytes whose i_wb_sel bit is 1.
REQ-021 In-window read: the word SHALL be read on the accept edge; a read accepted the cycle after a write to the same word returns the new data.
REQ-022 Out-of-window: memory SHALL be untouched; the response is o_wb_err instead of o_wb_ack.
REQ-023 Each accepted request SHALL produce exactly one one-cycle o_wb_ack or o_wb_err, exactly LAT cycles after accept, in accept order.
REQ-024 The response pipeline SHALL be LAT stages of {valid, err, data}; back-to-back accepts give back-to-back responses (1 per cycle throughput).
REQ-025 o_wb_data SHALL carry read data when o_wb_ack is asserted for a read; otherwise its value is don't-care.
REQ-026 o_wb_ack and o_wb_err SHALL never be high in the same cycle.
REQ-027 i_wb_cyc low in any cycle SHALL clear all pipeline valid bits on that edge (abort); writes already performed remain.
REQ-028 Abort and a new accept SHALL not coincide, since accept requires i_wb_cyc.
REQ-029 o_err_count SHALL increment on each cycle o_wb_err is high and saturate at 16'hFFFF.
REQ-030 Requests SHALL continue to be serviced after an error within the same cycle.

Reset
REQ-031 While i_reset_n is low, all pipeline valid bits SHALL be 0 and o_wb_ack = 0, o_wb_err = 0, o_err_count = 0, o_wb_data = 0.
REQ-032 Memory contents SHALL not be reset.
REQ-033 Reset asserted mid-transaction SHALL discard all pending responses; no ack or err is emitted for them after release.

Structure
REQ-034 LAT range limits and the error-counter width SHALL live in a shared constants package, wb_memwin_pkg.
REQ-035 Byte-enabled storage SHALL be the sub-module wb_bytemem (MAW, DW; registered read, per-byte write), inferable as block RAM.

Verification
REQ-036 Test 1 (defaults): write 32'hDEADBEEF, sel 4'hF, addr 28'h0008010, then read the same address -> ack 1 cycle after each accept; read data 32'hDEADBEEF.
REQ-037 Test 2: write 32'h11223344 with sel 4'b0101 over 32'hAABBCCDD -> read returns 32'hAA22CC44.
REQ-038 Test 3: read addr 28'h0010000 (upper bits 2) -> o_wb_err 1 cycle later, no ack, o_err_count = 1.
REQ-039 Test 4: LAT = 3; four back-to-back reads, then i_stall_req high for 2 cycles mid-burst -> no accepts while stalled; 4 acks, each 3 cycles after its accept, in order.
REQ-040 Test 5: LAT = 4; drop i_wb_cyc 2 cycles after accept -> no ack is emitted; a subsequent write and readback succeed.
REQ-041 Test 6: force 65 537 errors -> o_err_count holds 16'hFFFF; i_reset_n pulse -> 0 with no pending response.
